sample_readout: RTL and testbench
=================================

SAMPLE_READOUT -- requirements
Module: sample_readout

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 10, sample-RAM address width.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic (fpga main clock domain).
REQ-003 SHALL have port rstn, input, 1, reset, synchronous active-low.
REQ-004 SHALL have port start, input, 1, single-cycle readout request.
REQ-005 SHALL have port data_ready, input, 1, capture complete, RAM holds a valid event.
REQ-006 SHALL have port wraddress_triggerpoint, input, RAM_WIDTH, RAM address at trigger.
REQ-007 SHALL have port triggerpoint, input, RAM_WIDTH, number of pre-trigger samples.
REQ-008 SHALL have port nsmp, input, RAM_WIDTH, samples per channel to send.
REQ-009 SHALL have port chmask, input, 4, channels to send, bit n = channel n.
REQ-010 SHALL have ports rddata1..rddata4, input, 8 each, RAM read data, valid one cycle after rden.
REQ-011 SHALL have port rden, output, 1, RAM read enable.
REQ-012 SHALL have port rdaddress, output, RAM_WIDTH, RAM read address.
REQ-013 SHALL have port out_valid, output, 1, out_data valid.
REQ-014 SHALL have port out_data, output, 8, byte stream to host link.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts byte when high with out_valid.
REQ-016 SHALL have ports busy, done, abort, output, 1 each: readout active, completion pulse, abort pulse.

Function
REQ-017 SHALL use states IDLE, SETUP, READ, LATCH, SEND, DONE.
REQ-018 IDLE: start && data_ready -> SETUP, latching nsmp, chmask, and base = (wraddress_triggerpoint - triggerpoint) mod 2^RAM_WIDTH.
REQ-019 start while not IDLE, or while data_ready low, SHALL be ignored.
REQ-020 SETUP: selects lowest set chmask bit, sample index 0, -> READ; chmask==0 or nsmp==0 -> DONE with no bytes sent.
REQ-021 READ: rden=1 for exactly one cycle, rdaddress=(base+index) mod 2^RAM_WIDTH (wraps 1023->0), -> LATCH.
REQ-022 LATCH: captures rddata of selected channel into out_data, -> SEND.
REQ-023 SEND: out_valid=1, out_data stable until out_valid&&out_ready; on accept index+1; index==nsmp-1 -> next set chmask bit at index 0 (READ) or, if none, DONE; else READ.
REQ-024 Byte order SHALL be channel ascending, each channel's samples in ascending address from base.
REQ-025 DONE: done=1 for one cycle, -> IDLE.
REQ-026 data_ready low in any state except IDLE/DONE SHALL force IDLE next cycle, abort=1 one cycle, out_valid=0, no done.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 Minimum per-byte cost SHALL be 3 cycles (READ, LATCH, SEND with out_ready high).
REQ-029 rden SHALL be low outside READ; rdaddress holds last value.

Reset
REQ-030 rstn low at a clk edge SHALL force IDLE, rden=0, rdaddress=0, out_valid=0, out_data=0, busy=0, done=0, abort=0, counters 0, mid-transfer included; no abort pulse.

Configuration
REQ-031 With READOUT_HEADER_EN defined, SETUP SHALL first emit 4 handshaked bytes 0xA5, {4'b0,chmask}, base[15:8] zero-extended, base[7:0], then samples; chmask==0 or nsmp==0 still sends header, then DONE.
REQ-032 Without READOUT_HEADER_EN, only sample bytes SHALL be emitted.

Structure
REQ-033 Shared package oscillo_pkg SHALL hold state enum, RAM_WIDTH default, header sync byte 0xA5.
REQ-034 No sub-module; single module.

Verification
REQ-035 wraddress_triggerpoint=100, triggerpoint=10, nsmp=4, chmask=0001, out_ready=1 -> addresses 90..93, 4 bytes from rddata1, done once.
REQ-036 wraddress_triggerpoint=5, triggerpoint=10, nsmp=8 -> addresses 1019..1023, 0, 1, 2.
REQ-037 chmask=1010, nsmp=2 -> ch1 two bytes then ch3 two bytes, 4 total; chmask=0000 -> done 2 cycles after start, zero bytes.
REQ-038 out_ready low 5 cycles mid-stream -> out_data stable, no extra rden, no byte lost or duplicated.
REQ-039 data_ready dropped after byte 3 -> abort pulse, IDLE next cycle, no done; rstn low mid-transfer -> all outputs 0 next cycle.
REQ-040 READOUT_HEADER_EN, chmask=0101, base=0x12 -> A5, 05, 00, 12 precede samples.

Source files
------------

// File: rtl/oscillo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : oscillo_pkg
//  Purpose  : Definitions shared by the oscilloscope readout logic: the readout
//             FSM state encoding, the default sample-RAM address width, the
//             header sync byte, and a helper that picks the lowest enabled
//             channel from a 4-bit channel mask.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package oscillo_pkg;

  // Default sample-RAM address width (1024-deep capture RAM)
  localparam int unsigned c_RAM_WIDTH_DEFAULT = 10;

  // First byte of the optional readout header, lets the host resynchronise
  localparam logic [7:0] c_HEADER_SYNC = 8'hA5;

  // Readout FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4,
    ST_DONE  = 3'd5
  } readout_state_e;

  // Index of the lowest set bit of a channel mask (0 when the mask is empty;
  // callers check for an empty mask separately).
  function automatic logic [1:0] lowest_channel(input logic [3:0] mask);
    lowest_channel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_channel = 2'(i);
      end
    end
  endfunction

endpackage : oscillo_pkg
`default_nettype wire

// File: rtl/sample_readout.sv
`default_nettype none
// ============================================================================
//  Module   : sample_readout
//  Purpose  : Streams a captured event out of the 4-channel sample RAM as a
//             byte stream with a valid/ready handshake. Samples are read
//             starting at base = wraddress_triggerpoint - triggerpoint
//             (modulo RAM depth), nsmp samples per enabled channel, channels
//             in ascending order. Each byte costs at least READ, LATCH, SEND.
//  Options  : READOUT_HEADER_EN - when defined, a 4-byte header
//             (A5, chmask, base[15:8], base[7:0]) is sent before the samples.
//  Ports    : clk                    - single clock
//             rstn                   - synchronous active-low reset
//             start                  - single-cycle readout request
//             data_ready             - capture RAM holds a valid event
//             wraddress_triggerpoint - RAM address at trigger
//             triggerpoint           - number of pre-trigger samples
//             nsmp                   - samples per channel to send
//             chmask                 - channel enable mask (bit n = channel n)
//             rddata1..rddata4       - RAM read data, one cycle after rden
//             rden / rdaddress       - RAM read port
//             out_valid / out_data   - byte stream to host link
//             out_ready              - downstream accepts byte
//             busy / done / abort    - status: active, completion, abort pulse
//  Revision : 1.0 - initial release
// ============================================================================
module sample_readout
  import oscillo_pkg::*;
#(
  parameter int RAM_WIDTH = c_RAM_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
  input  logic [RAM_WIDTH-1:0] triggerpoint,
  input  logic [RAM_WIDTH-1:0] nsmp,
  input  logic [3:0]           chmask,
  input  logic [7:0]           rddata1,
  input  logic [7:0]           rddata2,
  input  logic [7:0]           rddata3,
  input  logic [7:0]           rddata4,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 abort
);

  // State constants, taken from the shared enum encoding
  localparam logic [2:0] c_IDLE  = ST_IDLE;
  localparam logic [2:0] c_SETUP = ST_SETUP;
  localparam logic [2:0] c_READ  = ST_READ;
  localparam logic [2:0] c_LATCH = ST_LATCH;
  localparam logic [2:0] c_SEND  = ST_SEND;
  localparam logic [2:0] c_DONE  = ST_DONE;

  localparam logic [RAM_WIDTH-1:0] c_ONE = RAM_WIDTH'(1);

  logic [2:0]           r_state;
  logic [RAM_WIDTH-1:0] r_base;
  logic [RAM_WIDTH-1:0] r_nsmp;
  logic [3:0]           r_mask;      // channels still to be sent
  logic [1:0]           r_chan;      // channel currently being sent
  logic [RAM_WIDTH-1:0] r_index;     // sample index within current channel
  logic [RAM_WIDTH-1:0] r_rdaddress;
  logic [7:0]           r_out_data;
  logic                 r_abort;

  logic                 w_abort;
  logic                 w_hdr_done;
  logic [7:0]           w_rd_sel;
  logic [3:0]           w_mask_rem;
  logic [RAM_WIDTH-1:0] w_index_next;
  logic                 w_last_sample;

`ifdef READOUT_HEADER_EN
  logic [1:0]  r_hdr_cnt;
  logic [15:0] w_base16;
  logic [7:0]  w_hdr_next;

  assign w_base16 = 16'(r_base);

  // Header byte following the one currently presented
  always_comb begin
    w_hdr_next = c_HEADER_SYNC;
    case (r_hdr_cnt)
      2'd0:    w_hdr_next = {4'b0000, r_mask};
      2'd1:    w_hdr_next = w_base16[15:8];
      2'd2:    w_hdr_next = w_base16[7:0];
      default: w_hdr_next = c_HEADER_SYNC;
    endcase
  end

  // Sample setup proceeds only once the last header byte is accepted
  assign w_hdr_done = (r_hdr_cnt == 2'd3) && out_ready;
`else
  assign w_hdr_done = 1'b1;
`endif

  // Losing the event mid-readout aborts; IDLE and DONE are not affected
  assign w_abort = !data_ready &&
                   ((r_state == c_SETUP) || (r_state == c_READ) ||
                    (r_state == c_LATCH) || (r_state == c_SEND));

  always_comb begin
    w_rd_sel = rddata1;
    case (r_chan)
      2'd0:    w_rd_sel = rddata1;
      2'd1:    w_rd_sel = rddata2;
      2'd2:    w_rd_sel = rddata3;
      default: w_rd_sel = rddata4;
    endcase
  end

  assign w_mask_rem    = r_mask & ~(4'b0001 << r_chan);
  assign w_index_next  = r_index + c_ONE;
  assign w_last_sample = (r_index == (r_nsmp - c_ONE));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= c_IDLE;
      r_base      <= '0;
      r_nsmp      <= '0;
      r_mask      <= 4'd0;
      r_chan      <= 2'd0;
      r_index     <= '0;
      r_rdaddress <= '0;
      r_out_data  <= 8'd0;
      r_abort     <= 1'b0;
`ifdef READOUT_HEADER_EN
      r_hdr_cnt   <= 2'd0;
`endif
    end else begin
      r_abort <= 1'b0;
      if (w_abort) begin
        r_state <= c_IDLE;
        r_abort <= 1'b1;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (start && data_ready) begin
              r_state <= c_SETUP;
              r_nsmp  <= nsmp;
              r_mask  <= chmask;
              // Unsigned subtraction wraps modulo the RAM depth
              r_base  <= wraddress_triggerpoint - triggerpoint;
`ifdef READOUT_HEADER_EN
              r_hdr_cnt  <= 2'd0;
              r_out_data <= c_HEADER_SYNC;
`endif
            end
          end

          c_SETUP: begin
            if (w_hdr_done) begin
              if ((r_mask == 4'd0) || (r_nsmp == '0)) begin
                r_state <= c_DONE;
              end else begin
                r_chan      <= lowest_channel(r_mask);
                r_index     <= '0;
                r_rdaddress <= r_base;
                r_state     <= c_READ;
              end
            end
`ifdef READOUT_HEADER_EN
            else if (out_ready) begin
              r_hdr_cnt  <= r_hdr_cnt + 2'd1;
              r_out_data <= w_hdr_next;
            end
`endif
          end

          c_READ: begin
            r_state <= c_LATCH;
          end

          c_LATCH: begin
            r_out_data <= w_rd_sel;
            r_state    <= c_SEND;
          end

          c_SEND: begin
            if (out_ready) begin
              if (w_last_sample) begin
                r_mask <= w_mask_rem;
                if (w_mask_rem != 4'd0) begin
                  r_chan      <= lowest_channel(w_mask_rem);
                  r_index     <= '0;
                  r_rdaddress <= r_base;
                  r_state     <= c_READ;
                end else begin
                  r_state <= c_DONE;
                end
              end else begin
                r_index     <= w_index_next;
                r_rdaddress <= r_base + w_index_next;
                r_state     <= c_READ;
              end
            end
          end

          c_DONE: begin
            r_state <= c_IDLE;
          end

          default: begin
            r_state <= c_IDLE;
          end
        endcase
      end
    end
  end

  assign rden      = (r_state == c_READ);
  assign rdaddress = r_rdaddress;
`ifdef READOUT_HEADER_EN
  assign out_valid = (r_state == c_SEND) || (r_state == c_SETUP);
`else
  assign out_valid = (r_state == c_SEND);
`endif
  assign out_data  = r_out_data;
  assign busy      = (r_state != c_IDLE);
  assign done      = (r_state == c_DONE);
  assign abort     = r_abort;

endmodule : sample_readout
`default_nettype wire

// File: tb/tb_sample_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_readout
//  Purpose  : Self-checking bench for sample_readout. A behavioural RAM returns
//             a per-channel address pattern; expected bytes and read addresses
//             are queued when a readout is requested and compared as the DUT
//             produces them. Honours READOUT_HEADER_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sample_readout;
  import oscillo_pkg::*;

  localparam int RW = 10;
`ifdef READOUT_HEADER_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          data_ready;
  logic [RW-1:0] wraddress_triggerpoint;
  logic [RW-1:0] triggerpoint;
  logic [RW-1:0] nsmp;
  logic [3:0]    chmask;
  logic [7:0]    rddata1, rddata2, rddata3, rddata4;
  logic          rden;
  logic [RW-1:0] rdaddress;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          busy, done, abort;

  always #5 clk = ~clk;

  sample_readout #(.RAM_WIDTH(RW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .data_ready(data_ready),
    .wraddress_triggerpoint(wraddress_triggerpoint), .triggerpoint(triggerpoint),
    .nsmp(nsmp), .chmask(chmask),
    .rddata1(rddata1), .rddata2(rddata2), .rddata3(rddata3), .rddata4(rddata4),
    .rden(rden), .rdaddress(rdaddress), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .abort(abort)
  );

  function automatic logic [7:0] ram_val(input int ch, input int addr);
    ram_val = 8'((addr * 7) ^ (addr >> 2) ^ (ch * 53));
  endfunction

  // Behavioural sample RAM: registered read
  always @(posedge clk) begin
    if (rden) begin
      rddata1 <= ram_val(0, int'(rdaddress));
      rddata2 <= ram_val(1, int'(rdaddress));
      rddata3 <= ram_val(2, int'(rdaddress));
      rddata4 <= ram_val(3, int'(rdaddress));
    end
  end

  logic [7:0]    exp_q[$];
  logic [RW-1:0] addr_q[$];
  int checks = 0, failures = 0;
  int acc_cnt = 0, done_cnt = 0, abort_cnt = 0, rd_cnt = 0;
  logic          capture_first = 1'b0;
  logic [RW-1:0] first_addr = '0;
  logic [7:0]    mon_b;
  logic [RW-1:0] mon_a;

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL byte_unexpected got=%02h", out_data);
        end else begin
          mon_b = exp_q.pop_front();
          if (out_data !== mon_b) begin
            failures++;
            $display("FAIL byte got=%02h exp=%02h", out_data, mon_b);
          end
        end
        acc_cnt++;
      end
      if (rden) begin
        checks++;
        if (addr_q.size() == 0) begin
          failures++;
          $display("FAIL rden_unexpected addr=%0d", rdaddress);
        end else begin
          mon_a = addr_q.pop_front();
          if (rdaddress !== mon_a) begin
            failures++;
            $display("FAIL rdaddress got=%0d exp=%0d", rdaddress, mon_a);
          end
        end
        if (capture_first) begin
          first_addr    = rdaddress;
          capture_first = 1'b0;
        end
        rd_cnt++;
      end
      if (done)  done_cnt++;
      if (abort) abort_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input int wr, input int tr, input int n, input logic [3:0] m);
    int base;
    base = (wr - tr + 1024) % 1024;
`ifdef READOUT_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'b0000, m});
    exp_q.push_back(8'(base >> 8));
    exp_q.push_back(8'(base & 255));
`endif
    if (m != 4'd0 && n != 0) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (m[ch]) begin
          for (int i = 0; i < n; i++) begin
            addr_q.push_back(RW'((base + i) % 1024));
            exp_q.push_back(ram_val(ch, (base + i) % 1024));
          end
        end
      end
    end
  endtask

  task automatic setup_run(input int wr, input int tr, input int n, input logic [3:0] m);
    wraddress_triggerpoint = RW'(wr);
    triggerpoint           = RW'(tr);
    nsmp                   = RW'(n);
    chmask                 = m;
    push_expected(wr, tr, n, m);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int done0, input int rmode, input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (done_cnt != done0) break;
      @(posedge clk); #1;
      out_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b1;
    if (k == 3000) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=no_done exp=done", name);
    end
  endtask

  task automatic wait_acc(input int target, input string name);
    int k;
    for (k = 0; k < 1000; k++) begin
      if (acc_cnt >= target) break;
      @(posedge clk); #1;
    end
    if (k == 1000) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=%0d exp=%0d", name, acc_cnt, target);
    end
  endtask

  task automatic flush_scoreboard();
    exp_q.delete();
    addr_q.delete();
  endtask

  typedef struct {
    int         wr;
    int         tr;
    int         n;
    logic [3:0] m;
    int         rmode;      // 0: out_ready always high, 1: random backpressure
    int         exp_bytes;  // sample bytes (header excluded)
    int         exp_first;  // first read address
  } vec_t;

  vec_t vecs[7];

  initial begin
    int acc0, done0, rd0, ab0;
    logic [7:0] held;

    vecs[0] = '{100,   10, 4, 4'b0001, 0, 4,  90};
    vecs[1] = '{5,     10, 8, 4'b0001, 0, 8,  1019};
    vecs[2] = '{200,    0, 2, 4'b1010, 1, 4,  200};
    vecs[3] = '{50,     7, 5, 4'b0000, 0, 0,  0};
    vecs[4] = '{50,     7, 0, 4'b1111, 0, 0,  0};
    vecs[5] = '{32,    14, 3, 4'b0101, 1, 6,  18};
    vecs[6] = '{1023,   0, 3, 4'b1000, 0, 3,  1023};

    rstn = 1'b0; start = 1'b0; data_ready = 1'b1; out_ready = 1'b1;
    wraddress_triggerpoint = '0; triggerpoint = '0; nsmp = '0; chmask = 4'd0;
    rddata1 = 8'd0; rddata2 = 8'd0; rddata3 = 8'd0; rddata4 = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden", 32'(rden), 0);
    chk("rst_rdaddress", 32'(rdaddress), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_abort", 32'(abort), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven readouts
    for (int v = 0; v < 7; v++) begin
      acc0 = acc_cnt; done0 = done_cnt; rd0 = rd_cnt;
      setup_run(vecs[v].wr, vecs[v].tr, vecs[v].n, vecs[v].m);
      capture_first = 1'b1;
      pulse_start();
      wait_done(done0, vecs[v].rmode, "vec_done");
      repeat (3) @(posedge clk);
      #1;
      chk("vec_done_once", 32'(done_cnt - done0), 1);
      chk("vec_bytes", 32'(acc_cnt - acc0), 32'(vecs[v].exp_bytes + HDR));
      chk("vec_reads", 32'(rd_cnt - rd0), 32'(vecs[v].exp_bytes));
      chk("vec_queue_empty", 32'(exp_q.size() + addr_q.size()), 0);
      if (vecs[v].exp_bytes > 0)
        chk("vec_first_addr", 32'(first_addr), 32'(vecs[v].exp_first));
      chk("vec_busy_after", 32'(busy), 0);
      capture_first = 1'b0;
    end

`ifndef READOUT_HEADER_EN
    // Empty mask: done two cycles after start
    done0 = done_cnt; acc0 = acc_cnt;
    setup_run(10, 0, 4, 4'b0000);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("empty_done_early", 32'(done), 0);
    chk("empty_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("empty_done_at_2", 32'(done), 1);
    @(posedge clk); #1;
    chk("empty_no_bytes", 32'(acc_cnt - acc0), 0);
`endif

    // Backpressure: out_ready low for 5 cycles mid-stream
    acc0 = acc_cnt; done0 = done_cnt;
    setup_run(300, 0, 6, 4'b0010);
    pulse_start();
    wait_acc(acc0 + HDR + 2, "stall_pre");
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    held = out_data;
    rd0  = rd_cnt;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data_stable", 32'(out_data), 32'(held));
    end
    chk("stall_no_rden", 32'(rd_cnt - rd0), 0);
    out_ready = 1'b1;
    wait_done(done0, 0, "stall_done");
    @(posedge clk); #1;
    chk("stall_bytes", 32'(acc_cnt - acc0), 32'(HDR + 6));
    chk("stall_queue_empty", 32'(exp_q.size() + addr_q.size()), 0);

    // Abort: data_ready dropped after the third sample byte
    acc0 = acc_cnt; done0 = done_cnt; ab0 = abort_cnt;
    setup_run(500, 0, 8, 4'b0001);
    pulse_start();
    wait_acc(acc0 + HDR + 3, "abort_pre");
    data_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_pulse", 32'(abort), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_rden", 32'(rden), 0);
    @(posedge clk); #1;
    chk("abort_one_cycle", 32'(abort), 0);
    flush_scoreboard();
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - done0), 0);
    chk("abort_count", 32'(abort_cnt - ab0), 1);
    data_ready = 1'b1;

    // start ignored while data_ready is low
    ab0 = abort_cnt; done0 = done_cnt;
    data_ready = 1'b0;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    chk("nodata_busy", 32'(busy), 0);
    chk("nodata_no_done", 32'(done_cnt - done0), 0);
    data_ready = 1'b1;

    // Reset in the middle of a transfer
    acc0 = acc_cnt; ab0 = abort_cnt;
    setup_run(1, 0, 8, 4'b1100);
    pulse_start();
    wait_acc(acc0 + HDR + 2, "rst_pre");
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rden", 32'(rden), 0);
    chk("midrst_rdaddress", 32'(rdaddress), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_abort", 32'(abort), 0);
    flush_scoreboard();
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_abort", 32'(abort_cnt - ab0), 0);
    chk("midrst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sample_readout
`default_nettype wire
